segre_dcache_data_array: RTL

N-way set-associative data storage for the Segre L1 data cache, the parametrised successor of the single-way dcache data store. It serves one core load/store per cycle with a registered 1-cycle read response, sign extension and misalignment detection. It also runs multi-beat line refills from the MMU and multi-beat line evictions toward it through a small control FSM. It sits between the dcache controller (tag/hit logic, way select) and the MMU.

---
 rtl/segre_dcache_data_array_pkg.sv | 35 +++
 rtl/segre_dcache_data_array_if.sv | 90 +++++++++
 rtl/segre_dcache_data_array_load_align.sv | 63 ++++++
 rtl/segre_dcache_data_array.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_dcache_data_array_pkg.sv
// Shared types and defaults for the Segre L1 data cache data array.
//
// Contents:
//   DCACHE_NUM_WAYS, DCACHE_NUM_SETS, DCACHE_LANE_BYTES, DCACHE_BEAT_BYTES
//     - default geometry of the data array
//   memop_data_type_e  - access size of a core load/store (BYTE/HALF/WORD)
//   dcache_fsm_state_e - refill/evict control FSM states
//   even_parity()      - per-byte parity helper, used when the optional
//                        SEGRE_DCACHE_PARITY_EN parity storage is built
package segre_dcache_data_array_pkg;

  localparam int DCACHE_NUM_WAYS   = 2;
  localparam int DCACHE_NUM_SETS   = 16;
  localparam int DCACHE_LANE_BYTES = 16;
  localparam int DCACHE_BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    EVICT = 2'b10
  } dcache_fsm_state_e;

  // Parity bit that makes the 9-bit {parity, data} group have an even
  // number of ones.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/segre_dcache_data_array_if.sv
// Bus interface of the dcache data array: core access port, MMU refill
// port and MMU evict port.
//
// Modports:
//   slave  - the data array itself
//   master - the dcache controller / MMU side driving it
//
// Optional feature macro: SEGRE_DCACHE_PARITY_EN adds parity_err_o.
interface segre_dcache_data_array_if
  import segre_dcache_data_array_pkg::*;
#(
  parameter int NUM_WAYS   = DCACHE_NUM_WAYS,
  parameter int NUM_SETS   = DCACHE_NUM_SETS,
  parameter int LANE_BYTES = DCACHE_LANE_BYTES,
  parameter int BEAT_BYTES = DCACHE_BEAT_BYTES
) ();

  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int IDX_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int OFF_W = $clog2(LANE_BYTES);
  localparam int BEAT_W = BEAT_BYTES * 8;

  // core access
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [WAY_W-1:0] req_way_i;
  logic [IDX_W-1:0] req_index_i;
  logic [OFF_W-1:0] req_byte_i;
  memop_data_type_e req_type_i;
  logic             req_sext_i;
  logic [31:0]      req_wdata_i;
  logic             rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_misaligned_o;

  // refill from MMU
  logic              fill_req_i;
  logic              fill_ack_o;
  logic [WAY_W-1:0]  fill_way_i;
  logic [IDX_W-1:0]  fill_index_i;
  logic              fill_valid_i;
  logic [BEAT_W-1:0] fill_data_i;
  logic              fill_done_o;

  // eviction toward MMU
  logic              evict_req_i;
  logic              evict_ack_o;
  logic [WAY_W-1:0]  evict_way_i;
  logic [IDX_W-1:0]  evict_index_i;
  logic              evict_valid_o;
  logic              evict_ready_i;
  logic [BEAT_W-1:0] evict_data_o;
  logic              evict_last_o;

  logic busy_o;

`ifdef SEGRE_DCACHE_PARITY_EN
  logic parity_err_o;
`endif

  modport slave (
    input  req_valid_i, req_we_i, req_way_i, req_index_i, req_byte_i,
           req_type_i, req_sext_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misaligned_o,
    input  fill_req_i, fill_way_i, fill_index_i, fill_valid_i, fill_data_i,
    output fill_ack_o, fill_done_o,
    input  evict_req_i, evict_way_i, evict_index_i, evict_ready_i,
    output evict_ack_o, evict_valid_o, evict_data_o, evict_last_o,
`ifdef SEGRE_DCACHE_PARITY_EN
    output parity_err_o,
`endif
    output busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_way_i, req_index_i, req_byte_i,
           req_type_i, req_sext_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_misaligned_o,
    output fill_req_i, fill_way_i, fill_index_i, fill_valid_i, fill_data_i,
    input  fill_ack_o, fill_done_o,
    output evict_req_i, evict_way_i, evict_index_i, evict_ready_i,
    input  evict_ack_o, evict_valid_o, evict_data_o, evict_last_o,
`ifdef SEGRE_DCACHE_PARITY_EN
    input  parity_err_o,
`endif
    input  busy_o
  );

endinterface

// File: rtl/segre_dcache_data_array_load_align.sv
// Load alignment unit: picks the byte/half/word addressed by byte_off out
// of a full cache line, zero- or sign-extends it to 32 bits and flags
// misaligned accesses (data forced to 0 then). Kept generic so the icache
// can reuse it.
//
// Ports:
//   line       in  full cache line, byte 0 in the low bits
//   byte_off   in  byte offset inside the line
//   data_type  in  BYTE/HALF/WORD
//   sext       in  sign-extend BYTE/HALF results
//   rdata      out aligned, extended data
//   misaligned out HALF on odd offset or WORD not on a 4-byte boundary
module segre_dcache_data_array_load_align
  import segre_dcache_data_array_pkg::*;
#(
  parameter int LANE_BYTES = DCACHE_LANE_BYTES
) (
  input  logic [LANE_BYTES*8-1:0]      line,
  input  logic [$clog2(LANE_BYTES)-1:0] byte_off,
  input  memop_data_type_e             data_type,
  input  logic                         sext,
  output logic [31:0]                  rdata,
  output logic                         misaligned
);

  logic [31:0] word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // The containing 32-bit word is selected first; byte/half selection then
  // only needs the two low offset bits.
  always_comb begin
    word = '0;
    for (int w = 0; w < LANE_BYTES / 4; w++) begin
      if (int'(byte_off) / 4 == w) word = line[w*32 +: 32];
    end
    case (byte_off[1:0])
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata      = '0;
    misaligned = 1'b0;
    case (data_type)
      BYTE: rdata = {{24{sext & sel_byte[7]}}, sel_byte};
      HALF: begin
        if (byte_off[0]) misaligned = 1'b1;
        else rdata = {{16{sext & sel_half[15]}}, sel_half};
      end
      WORD: begin
        if (byte_off[1:0] != 2'b00) misaligned = 1'b1;
        else rdata = word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/segre_dcache_data_array.sv
// N-way set-associative data storage of the Segre L1 dcache. Serves one
// core load/store per cycle with a registered response, and runs
// multi-beat line refills from / evictions to the MMU through a small
// IDLE/FILL/EVICT FSM. Evict/refill requests take priority over the core.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (FSM, counter, response regs;
//          the storage array itself is not reset)
//   bus    segre_dcache_data_array_if.slave (core, refill, evict ports)
//
// Optional feature macro: SEGRE_DCACHE_PARITY_EN adds one even-parity bit
// per stored byte, checked on core loads and evicted beats and reported
// on parity_err_o.
module segre_dcache_data_array
  import segre_dcache_data_array_pkg::*;
#(
  parameter int NUM_WAYS   = DCACHE_NUM_WAYS,
  parameter int NUM_SETS   = DCACHE_NUM_SETS,
  parameter int LANE_BYTES = DCACHE_LANE_BYTES,
  parameter int BEAT_BYTES = DCACHE_BEAT_BYTES
) (
  input logic clk_i,
  input logic rst_i,
  segre_dcache_data_array_if.slave bus
);

  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int IDX_W     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int LINE_W    = LANE_BYTES * 8;
  localparam int BEAT_W    = BEAT_BYTES * 8;
  localparam int NUM_BEATS = LANE_BYTES / BEAT_BYTES;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  logic [LINE_W-1:0] mem [NUM_WAYS][NUM_SETS];

  dcache_fsm_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              fill_ack, evict_ack;

  logic                     req_ready, access, store_en, fill_write;
  logic [LINE_W-1:0]        req_line;
  logic [LANE_BYTES-1:0]    byte_mask;
  logic [LANE_BYTES-1:0][7:0] wbytes;
  logic [31:0]              load_data;
  logic                     misaligned;

  logic        rsp_valid_q, rsp_mis_q;
  logic [31:0] rsp_rdata_q;

  logic [LINE_W-1:0] evict_line;
  logic [BEAT_W-1:0] evict_beat;

  assign req_ready  = (state_q == IDLE) & ~bus.evict_req_i & ~bus.fill_req_i;
  assign access     = bus.req_valid_i & req_ready;
  assign store_en   = access & bus.req_we_i & ~misaligned;
  assign fill_write = (state_q == FILL) & bus.fill_valid_i;
  assign req_line   = mem[bus.req_way_i][bus.req_index_i];

  segre_dcache_data_array_load_align #(
    .LANE_BYTES(LANE_BYTES)
  ) u_load_align (
    .line      (req_line),
    .byte_off  (bus.req_byte_i),
    .data_type (bus.req_type_i),
    .sext      (bus.req_sext_i),
    .rdata     (load_data),
    .misaligned(misaligned)
  );

  // Bytes touched by the core access, and the store byte that lands in each
  // lane. Accesses are naturally aligned, so lane b of a HALF/WORD takes
  // store byte b%2 / b%4.
  always_comb begin
    byte_mask = '0;
    wbytes    = '0;
    for (int b = 0; b < LANE_BYTES; b++) begin
      case (bus.req_type_i)
        BYTE: begin
          byte_mask[b] = (b == int'(bus.req_byte_i));
          wbytes[b]    = bus.req_wdata_i[7:0];
        end
        HALF: begin
          byte_mask[b] = (b / 2 == int'(bus.req_byte_i) / 2);
          wbytes[b]    = bus.req_wdata_i[(b%2)*8 +: 8];
        end
        WORD: begin
          byte_mask[b] = (b / 4 == int'(bus.req_byte_i) / 4);
          wbytes[b]    = bus.req_wdata_i[(b%4)*8 +: 8];
        end
        default: ;
      endcase
    end
  end

`ifdef SEGRE_DCACHE_PARITY_EN
  logic [LANE_BYTES-1:0] par_mem [NUM_WAYS][NUM_SETS];
  logic                  load_perr, evict_perr, rsp_perr_q;
`endif

  // Storage array: core stores only happen in IDLE and refill beats only in
  // FILL, so the two write sources never collide.
  always_ff @(posedge clk_i) begin
    if (store_en) begin
      for (int b = 0; b < LANE_BYTES; b++) begin
        if (byte_mask[b]) begin
          mem[bus.req_way_i][bus.req_index_i][b*8 +: 8] <= wbytes[b];
`ifdef SEGRE_DCACHE_PARITY_EN
          par_mem[bus.req_way_i][bus.req_index_i][b] <= even_parity(wbytes[b]);
`endif
        end
      end
    end
    if (fill_write) begin
      for (int bt = 0; bt < NUM_BEATS; bt++) begin
        if (cnt_q == CNT_W'(bt)) begin
          mem[way_q][idx_q][bt*BEAT_W +: BEAT_W] <= bus.fill_data_i;
`ifdef SEGRE_DCACHE_PARITY_EN
          for (int j = 0; j < BEAT_BYTES; j++) begin
            par_mem[way_q][idx_q][bt*BEAT_BYTES + j] <=
              even_parity(bus.fill_data_i[j*8 +: 8]);
          end
`endif
        end
      end
    end
  end

  // Evicted beat is read combinationally from the latched line and stays
  // stable as long as the counter does not move.
  always_comb begin
    evict_line = mem[way_q][idx_q];
    evict_beat = '0;
    for (int bt = 0; bt < NUM_BEATS; bt++) begin
      if (cnt_q == CNT_W'(bt)) evict_beat = evict_line[bt*BEAT_W +: BEAT_W];
    end
  end

  // Control FSM state and latched line target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      way_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state: in IDLE evict wins over fill; both run one beat per
  // handshake and drop back to IDLE after the last beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    way_d     = way_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    fill_ack  = 1'b0;
    evict_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.evict_req_i) begin
          evict_ack = 1'b1;
          way_d     = bus.evict_way_i;
          idx_d     = bus.evict_index_i;
          cnt_d     = '0;
          state_d   = EVICT;
        end else if (bus.fill_req_i) begin
          fill_ack = 1'b1;
          way_d    = bus.fill_way_i;
          idx_d    = bus.fill_index_i;
          cnt_d    = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        if (bus.fill_valid_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EVICT: begin
        if (bus.evict_ready_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered core response; stores and misaligned accesses return 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_mis_q   <= 1'b0;
    end else begin
      rsp_valid_q <= access;
      rsp_rdata_q <= (access & ~bus.req_we_i) ? load_data : 32'd0;
      rsp_mis_q   <= access & misaligned;
    end
  end

`ifdef SEGRE_DCACHE_PARITY_EN
  // Parity checks on the bytes a load touches and on the current evict beat.
  always_comb begin
    load_perr  = 1'b0;
    evict_perr = 1'b0;
    for (int b = 0; b < LANE_BYTES; b++) begin
      if (byte_mask[b] &&
          par_mem[bus.req_way_i][bus.req_index_i][b] != even_parity(req_line[b*8 +: 8]))
        load_perr = 1'b1;
    end
    for (int bt = 0; bt < NUM_BEATS; bt++) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        if (cnt_q == CNT_W'(bt) &&
            par_mem[way_q][idx_q][bt*BEAT_BYTES + j] !=
              even_parity(evict_line[(bt*BEAT_BYTES + j)*8 +: 8]))
          evict_perr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rsp_perr_q <= 1'b0;
    else       rsp_perr_q <= access & ~bus.req_we_i & ~misaligned & load_perr;
  end

  assign bus.parity_err_o = rsp_perr_q | ((state_q == EVICT) & evict_perr);
`endif

  assign bus.req_ready_o      = req_ready;
  assign bus.rsp_valid_o      = rsp_valid_q;
  assign bus.rsp_rdata_o      = rsp_rdata_q;
  assign bus.rsp_misaligned_o = rsp_mis_q;
  assign bus.fill_ack_o       = fill_ack;
  assign bus.fill_done_o      = done_q;
  assign bus.evict_ack_o      = evict_ack;
  assign bus.evict_valid_o    = (state_q == EVICT);
  assign bus.evict_data_o     = (state_q == EVICT) ? evict_beat : '0;
  assign bus.evict_last_o     = (state_q == EVICT) & (cnt_q == LAST_BEAT);
  assign bus.busy_o           = (state_q != IDLE);

endmodule
